// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of one shared ALU, feeding a one-entry response register.
// Latency 1 cycle from accept to rsp_valid; a full, stalled response holds both req_ready low. Optional counters: ALU_ARB_PERF_CNT_EN.
module alu_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [3:0]        req0_ctrl,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [3:0]        req1_ctrl,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero
`ifdef ALU_ARB_PERF_CNT_EN
    ,
    output logic [31:0]       grant0_cnt,
    output logic [31:0]       grant1_cnt,
    output logic [31:0]       stall_cnt
`endif
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_last_grant;
    logic                r_rsp_id;
    logic                r_rsp_zero;
    logic [DATA_W-1:0]   r_rsp_result;

    logic                w_slot_free;
    logic                w_any_vld;
    logic                w_gnt_id;
    logic                w_accept;
    logic [DATA_W-1:0]   w_a;
    logic [DATA_W-1:0]   w_b;
    logic [3:0]          w_ctrl;
    logic [DATA_W-1:0]   w_alu_res;

    // On a tie the requester that did not win last time goes next.
    assign w_any_vld = req0_valid | req1_valid;
    assign w_gnt_id  = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        rsp_valid   = (r_state == S_FULL);
        w_slot_free = (r_state == S_EMPTY) || rsp_ready;
        w_accept    = !reset && w_slot_free && w_any_vld;
        req0_ready  = w_accept && !w_gnt_id;
        req1_ready  = w_accept && w_gnt_id;
        if (r_state == S_EMPTY) begin
            if (w_accept) begin
                w_state_nxt = S_FULL;
            end
        end else begin
            if (rsp_ready && !w_accept) begin
                w_state_nxt = S_EMPTY;
            end
        end
    end

    assign w_a    = w_gnt_id ? req1_a    : req0_a;
    assign w_b    = w_gnt_id ? req1_b    : req0_b;
    assign w_ctrl = w_gnt_id ? req1_ctrl : req0_ctrl;

    always_comb begin
        w_alu_res = '0;
        case (w_ctrl)
            4'b0000: w_alu_res = w_a & w_b;
            4'b0001: w_alu_res = w_a | w_b;
            4'b0010: w_alu_res = w_a + w_b;
            4'b0110: w_alu_res = w_a - w_b;
            4'b0111: w_alu_res = {{(DATA_W-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
            default: w_alu_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b1;
            r_rsp_id     <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            r_rsp_result <= w_alu_res;
            r_rsp_zero   <= (w_alu_res == '0);
            r_rsp_id     <= w_gnt_id;
            r_last_grant <= w_gnt_id;
        end
    end

    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_zero   = r_rsp_zero;

`ifdef ALU_ARB_PERF_CNT_EN
    logic [31:0] r_grant0_cnt;
    logic [31:0] r_grant1_cnt;
    logic [31:0] r_stall_cnt;

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant0_cnt <= '0;
            r_grant1_cnt <= '0;
            r_stall_cnt  <= '0;
        end else begin
            if (w_accept && !w_gnt_id && (r_grant0_cnt != '1)) begin
                r_grant0_cnt <= r_grant0_cnt + 32'd1;
            end
            if (w_accept && w_gnt_id && (r_grant1_cnt != '1)) begin
                r_grant1_cnt <= r_grant1_cnt + 32'd1;
            end
            if (w_any_vld && !w_accept && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign grant0_cnt = r_grant0_cnt;
    assign grant1_cnt = r_grant1_cnt;
    assign stall_cnt  = r_stall_cnt;
`endif

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports req0_valid, req1_valid  input  1  requester N presents an operation.
REQ-005 SHALL have ports req0_ready, req1_ready  output  1  requester N operation accepted this cycle.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  DATA_W  operands.
REQ-007 SHALL have ports req0_ctrl, req1_ctrl  input  4  ALU control code.
REQ-008 SHALL have port rsp_valid  output  1  response register holds a result.
REQ-009 SHALL have port rsp_ready  input  1  consumer takes response this cycle.
REQ-010 SHALL have port rsp_id  output  1  requester index that owns the response.
REQ-011 SHALL have port rsp_result  output  DATA_W  computed result.
REQ-012 SHALL have port rsp_zero  output  1  high when rsp_result is all zeros.

Function
REQ-013 SHALL contain one shared ALU; codes: 0000 AND, 0001 OR, 0010 ADD (wraps mod 2^DATA_W), 0110 SUB (wraps), 0111 signed less-than (result 1 or 0); any other code gives result 0.
REQ-014 SHALL treat the response register as a one-entry buffer; "slot free" = !rsp_valid or rsp_ready.
REQ-015 SHALL accept at most one request per cycle, only when slot free.
REQ-016 SHALL grant by round-robin: one valid requester wins; both valid -> requester other than last_grant wins.
REQ-017 SHALL assert reqN_ready combinationally only for the granted requester in a slot-free cycle; handshake = valid && ready.
REQ-018 SHALL load rsp_result, rsp_zero, rsp_id and set rsp_valid on the edge after acceptance (latency 1 cycle).
REQ-019 SHALL update last_grant only on an accepted handshake.
REQ-020 SHALL clear rsp_valid on rsp_valid && rsp_ready with no simultaneous acceptance; simultaneous drain and acceptance SHALL replace the entry with no bubble.
REQ-021 SHALL hold rsp_* stable while rsp_valid && !rsp_ready (backpressure); both req_ready stay low.
REQ-022 SHALL ignore req inputs of a non-granted requester; its request stays pending, no loss.
REQ-023 SHALL implement a two-state FSM: EMPTY (rsp_valid=0) -> FULL on acceptance; FULL -> EMPTY on drain without acceptance; FULL -> FULL on drain+accept or stall.

Reset
REQ-024 SHALL on reset clear rsp_valid, rsp_id, rsp_result to 0, set rsp_zero to 1, set last_grant to 1 (requester 0 wins first tie), FSM to EMPTY.
REQ-025 SHALL drive req0_ready, req1_ready low during reset cycles.
REQ-026 SHALL discard any held response on reset asserted mid-operation.

Configuration
REQ-027 SHALL, with ALU_ARB_PERF_CNT_EN defined, add outputs grant0_cnt, grant1_cnt, stall_cnt (32 bits each): grants per requester, cycles with any req valid but none accepted; saturate at all-ones; cleared by reset.
REQ-028 SHALL, without ALU_ARB_PERF_CNT_EN, omit those ports and counters entirely; all other behaviour identical.

Verification
REQ-029 Single: req0 ADD a=5 b=7, rsp_ready=1 -> req0_ready same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_result=12, rsp_zero=0.
REQ-030 Contention: both valid every cycle after reset, rsp_ready=1 -> grants 0,1,0,1; rsp_id alternates 0,1,0,1 with back-to-back rsp_valid.
REQ-031 Backpressure: req1 SUB 3-3 accepted, rsp_ready=0 for 4 cycles -> rsp_result=0, rsp_zero=1 held; req_ready low; release -> next request accepted same cycle.
REQ-032 Signed/wrap: SLT a=0xFFFFFFFF b=1 -> 1; ADD 0xFFFFFFFF+1 -> 0, rsp_zero=1; code 1111 -> 0.
REQ-033 Reset mid-op: response held with rsp_ready=0, assert reset 1 cycle -> rsp_valid=0, next tie granted to req0.
REQ-034 With ALU_ARB_PERF_CNT_EN: 3 grants to req0, 2 to req1, 4 stall cycles -> grant0_cnt=3, grant1_cnt=2, stall_cnt=4.
